// File: rtl/gray_stream_ctrl.sv
// Flow control and frame-geometry tracking around a 2-stage RGB-to-gray converter.
// Latency: LAT (=2) ce-enabled cycles from input handshake to m_valid.
// Backpressure: gp_ce/s_ready = m_ready | ~m_valid, combinational, no skid buffer.
module gray_stream_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [23:0] s_data,
  input  logic        s_sof,
  input  logic        s_eol,
  output logic        gp_ce,
  output logic [23:0] gp_rgb,
  input  logic [7:0]  gp_gray,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_sof,
  output logic        m_eol,
  output logic        frame_done,
  output logic        err_line,
  output logic        err_frame
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  typedef enum logic {WAIT_SOF = 1'b0, ACTIVE = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d, x_cur;
  logic [YW-1:0]   y_q, y_d, y_cur;
  // set after a line overran without eol: stray eols are ignored until the count matches
  logic            skip_q, skip_d, skip_cur;
  logic [LAT-1:0]  vld_q, sof_q, eol_q, eof_q;
  logic            err_line_q, err_line_d;
  logic            err_frame_q, err_frame_d;
  logic            hs, accept, line_end, eof_tag;

  assign m_valid    = vld_q[LAT-1];
  assign gp_ce      = m_ready | ~m_valid;
  assign s_ready    = gp_ce;
  assign gp_rgb     = s_data;
  assign m_data     = gp_gray;
  assign m_sof      = sof_q[LAT-1] & vld_q[LAT-1];
  assign m_eol      = eol_q[LAT-1] & vld_q[LAT-1];
  assign frame_done = m_valid & m_ready & eof_q[LAT-1];
  assign err_line   = err_line_q;
  assign err_frame  = err_frame_q;

  // In WAIT_SOF non-sof pixels are handshaken but dropped.
  assign hs     = s_valid & gp_ce;
  assign accept = hs & ((state_q == ACTIVE) | s_sof);

  // Next-state: pixel/line counting, line/frame error detection and eof tagging.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    skip_d      = skip_q;
    x_cur       = x_q;
    y_cur       = y_q;
    skip_cur    = skip_q;
    line_end    = 1'b0;
    eof_tag     = 1'b0;
    err_line_d  = 1'b0;
    err_frame_d = 1'b0;
    if (accept) begin
      state_d = ACTIVE;
      if (s_sof) begin
        // sof always restarts the frame; mid-frame it is also an error
        x_cur       = '0;
        y_cur       = '0;
        skip_cur    = 1'b0;
        err_frame_d = (state_q == ACTIVE);
      end
      if (x_cur == X_LAST) begin
        line_end   = 1'b1;
        err_line_d = ~s_eol;
        skip_d     = ~s_eol;
      end else if (s_eol && !skip_cur) begin
        line_end   = 1'b1;
        err_line_d = 1'b1;
        skip_d     = 1'b0;
      end else begin
        x_d    = x_cur + 1'b1;
        y_d    = y_cur;
        skip_d = skip_cur;
      end
      if (line_end) begin
        x_d = '0;
        if (y_cur == Y_LAST) begin
          y_d     = '0;
          eof_tag = 1'b1;
          skip_d  = 1'b0;
          state_d = WAIT_SOF;
        end else begin
          y_d = y_cur + 1'b1;
        end
      end
    end
  end

  // State, counters, error pulses and the ce-gated valid/sideband shift registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= WAIT_SOF;
      x_q         <= '0;
      y_q         <= '0;
      skip_q      <= 1'b0;
      vld_q       <= '0;
      sof_q       <= '0;
      eol_q       <= '0;
      eof_q       <= '0;
      err_line_q  <= 1'b0;
      err_frame_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      skip_q      <= skip_d;
      err_line_q  <= err_line_d;
      err_frame_q <= err_frame_d;
      if (gp_ce) begin
        vld_q <= {vld_q[LAT-2:0], accept};
        sof_q <= {sof_q[LAT-2:0], s_sof & accept};
        eol_q <= {eol_q[LAT-2:0], s_eol & accept};
        eof_q <= {eof_q[LAT-2:0], eof_tag};
      end
    end
  end

endmodule

// File: tb/tb_gray_stream_ctrl.sv
// Directed bench for gray_stream_ctrl with a behavioural 2-stage converter attached.
// Latency: checks 2-cycle handshake-to-m_valid and ordered output of each frame.
// Backpressure: m_ready driven constant-high, patterned 1,0,0,1 or held low per step.
module tb_gray_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [23:0] s_data = '0;
  logic        s_sof = 1'b0;
  logic        s_eol = 1'b0;
  logic        gp_ce;
  logic [23:0] gp_rgb;
  logic [7:0]  gp_gray;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [7:0]  m_data;
  logic        m_sof, m_eol, frame_done, err_line, err_frame;

  gray_stream_ctrl #(.IMG_W(4), .IMG_H(2), .LAT(2)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof), .s_eol(s_eol),
    .gp_ce(gp_ce), .gp_rgb(gp_rgb), .gp_gray(gp_gray),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol),
    .frame_done(frame_done), .err_line(err_line), .err_frame(err_frame)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gray(input logic [23:0] c);
    int s;
    s = 77 * int'(c[23:16]) + 150 * int'(c[15:8]) + 29 * int'(c[7:0]);
    return 8'(s >> 8);
  endfunction

  // Behavioural converter: two ce-enabled register stages.
  logic [7:0] cv1, cv2;
  always @(posedge clk) begin
    if (!rst) begin
      cv1 <= '0;
      cv2 <= '0;
    end else if (gp_ce) begin
      cv1 <= gray(gp_rgb);
      cv2 <= cv1;
    end
  end
  assign gp_gray = cv2;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mr_mode  = 0;
  logic [3:0] pat = 4'b1001;

  // Output monitor state, written only by the monitor process.
  logic [31:0] out_q[$];
  int          out_cyc_q[$];
  int          fd_cnt = 0, el_cnt = 0, ef_cnt = 0, stall_cnt = 0, viol = 0;
  logic        prev_stall = 1'b0;
  logic [9:0]  prev_out = '0;

  // Sample outputs mid-cycle: record handshakes, pulses and stall rules.
  always @(negedge clk) begin
    if (rst) begin
      if (m_valid && m_ready) begin
        out_q.push_back(32'({frame_done, m_eol, m_sof, m_data}));
        out_cyc_q.push_back(cyc);
      end
      if (frame_done) fd_cnt++;
      if (err_line) el_cnt++;
      if (err_frame) ef_cnt++;
      if (s_ready !== gp_ce) viol++;
      if (m_valid && !m_ready) begin
        stall_cnt++;
        if (gp_ce || s_ready) viol++;
      end else if (!gp_ce) begin
        viol++;
      end
      if (prev_stall && (!m_valid || {m_data, m_sof, m_eol} != prev_out)) viol++;
      prev_stall = m_valid && !m_ready;
      prev_out   = {m_data, m_sof, m_eol};
    end else begin
      prev_stall = 1'b0;
    end
  end

  logic [31:0] exp_q[$];
  int out_base = 0;
  int fd0, el0, ef0, st0, t_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    case (mr_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = pat[cyc[1:0]];
      default: m_ready = 1'b0;
    endcase
  endtask

  task automatic send(input logic [7:0] v, input logic sof, input logic eol,
                      input logic keep, input logic fd);
    int w;
    logic hs_seen;
    s_valid = 1'b1;
    s_data  = {v, v, v};
    s_sof   = sof;
    s_eol   = eol;
    w = 0;
    hs_seen = 1'b0;
    while (!hs_seen) begin
      @(negedge clk);
      hs_seen = s_ready;
      if (hs_seen) t_in = cyc;
      step();
      w++;
      if (!hs_seen && w > 50) begin
        chk("send_timeout", 32'd0, 32'd1);
        hs_seen = 1'b1;
      end
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
    if (keep) exp_q.push_back(32'({fd, eol, sof & keep, v}));
  endtask

  task automatic check_outputs(input string tag);
    int n;
    n = out_q.size() - out_base;
    chk({tag, "_count"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      chk({tag, "_px"}, out_q[out_base + i], exp_q[i]);
    exp_q.delete();
    out_base = out_q.size();
  endtask

  task automatic snap();
    fd0 = fd_cnt;
    el0 = el_cnt;
    ef0 = ef_cnt;
    st0 = stall_cnt;
  endtask

  task automatic drain(input int n);
    repeat (n) step();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // Reset state
    step(); step();
    @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_sof", 32'(m_sof), 32'd0);
    chk("rst_m_eol", 32'(m_eol), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_err_line", 32'(err_line), 32'd0);
    chk("rst_err_frame", 32'(err_frame), 32'd0);
    chk("rst_gp_ce", 32'(gp_ce), 32'd1);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    step();
    rst = 1'b1;
    step();

    // T1: continuous frame, all-white pixels, m_ready high
    snap();
    send(8'd255, 1, 0, 1, 0);
    begin : t1_lat
      int t0;
      t0 = t_in;
      for (int i = 1; i < 8; i++) send(8'd255, 1'b0, (i == 3 || i == 7), 1'b1, (i == 7));
      drain(4);
      chk("t1_latency", 32'(out_cyc_q[out_base] - t0), 32'd2);
    end
    check_outputs("t1");
    chk("t1_frame_done", 32'(fd_cnt - fd0), 32'd1);
    chk("t1_err_line", 32'(el_cnt - el0), 32'd0);
    chk("t1_err_frame", 32'(ef_cnt - ef0), 32'd0);

    // T2: same frame shape under m_ready pattern 1,0,0,1
    snap();
    mr_mode = 1;
    for (int i = 0; i < 8; i++)
      send(8'(8'h20 + i), (i == 0), (i == 3 || i == 7), 1'b1, (i == 7));
    drain(20);
    mr_mode = 0;
    drain(3);
    check_outputs("t2");
    chk("t2_frame_done", 32'(fd_cnt - fd0), 32'd1);
    chk("t2_stalls_seen", 32'(stall_cnt > st0), 32'd1);
    chk("t2_ce_rules", 32'(viol), 32'd0);

    // T3: three pixels without sof are dropped, then a valid frame
    snap();
    for (int i = 0; i < 3; i++) send(8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    drain(3);
    chk("t3_dropped", 32'(out_q.size() - out_base), 32'd0);
    for (int i = 0; i < 8; i++)
      send(8'(8'h40 + i), (i == 0), (i == 3 || i == 7), 1'b1, (i == 7));
    drain(4);
    check_outputs("t3");
    chk("t3_frame_done", 32'(fd_cnt - fd0), 32'd1);

    // T4: short line 0 (eol on pixel 2), then a good line 1
    snap();
    send(8'h60, 1, 0, 1, 0);
    send(8'h61, 0, 0, 1, 0);
    send(8'h62, 0, 1, 1, 0);
    send(8'h63, 0, 0, 1, 0);
    send(8'h64, 0, 0, 1, 0);
    send(8'h65, 0, 0, 1, 0);
    send(8'h66, 0, 1, 1, 1);
    drain(4);
    check_outputs("t4");
    chk("t4_err_line", 32'(el_cnt - el0), 32'd1);
    chk("t4_err_frame", 32'(ef_cnt - ef0), 32'd0);
    chk("t4_frame_done", 32'(fd_cnt - fd0), 32'd1);

    // T5: sof injected at pixel 5 restarts the frame
    snap();
    for (int i = 0; i < 5; i++) send(8'(8'h80 + i), (i == 0), (i == 3), 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      send(8'(8'h90 + i), (i == 0), (i == 3 || i == 7), 1'b1, (i == 7));
    drain(4);
    check_outputs("t5");
    chk("t5_err_frame", 32'(ef_cnt - ef0), 32'd1);
    chk("t5_err_line", 32'(el_cnt - el0), 32'd0);
    chk("t5_frame_done", 32'(fd_cnt - fd0), 32'd1);

    // T6: reset with two pixels stalled in flight
    snap();
    mr_mode = 2;
    step();
    send(8'hC0, 1, 0, 0, 0);
    send(8'hC1, 0, 0, 0, 0);
    @(negedge clk);
    chk("t6_inflight", 32'(m_valid), 32'd1);
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    mr_mode = 0;
    @(negedge clk);
    chk("t6_m_valid_after_rst", 32'(m_valid), 32'd0);
    step();
    send(8'hC2, 0, 0, 0, 0);
    drain(4);
    check_outputs("t6");
    chk("t6_frame_done", 32'(fd_cnt - fd0), 32'd0);
    chk("t6_err_frame", 32'(ef_cnt - ef0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_stream_ctrl.md
Name: gray_stream_ctrl

Overview:
Flow controller that sequences the two-stage RGB-to-gray converter inside a valid/ready video stream. It gates the converter's clock enable (ce) from downstream backpressure and tracks per-stage valid and sideband bits (sof/eol/eof) alongside the converter pipeline. It also counts pixels and lines against the configured frame geometry and flags malformed lines and frames. It sits between the camera/RGB stream and the background-reconstruction stage.

Parameters:
IMG_W, 640, active pixels per line (≥2)
IMG_H, 480, active lines per frame (≥2)
LAT, 2, converter latency in ce-enabled cycles (fixed at 2 to match the converter)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset; also drives converter rst
s_valid  in  1  input pixel valid
s_ready  out  1  input ready
s_data  in  24  RGB888, R in [23:16]
s_sof  in  1  first pixel of frame
s_eol  in  1  last pixel of line
gp_ce  out  1  converter clock enable
gp_rgb  out  24  converter rgb input; equals s_data
gp_gray  in  8  converter gray output
m_valid  out  1  output valid
m_ready  in  1  output ready
m_data  out  8  gray pixel; equals gp_gray
m_sof  out  1  sof aligned to m_data
m_eol  out  1  eol aligned to m_data
frame_done  out  1  1-cycle pulse when the last pixel of a frame completes its output handshake
err_line  out  1  1-cycle pulse on line-length mismatch
err_frame  out  1  1-cycle pulse on sof arriving mid-frame

Behaviour:
- Reset (rst=0 at clk edge): vld[1:0]=0, sideband shift regs=0, x=0, y=0, state=WAIT_SOF. m_valid, m_sof, m_eol, frame_done, err_line, err_frame all 0.
- Advance: gp_ce = m_ready | ~m_valid (combinational). s_ready = gp_ce. m_ready→s_ready is a combinational path by design; no skid buffer.
- Accept = s_valid & s_ready & (state accepts pixel). On each gp_ce cycle: vld <= {vld[0], accept}, and sof/eol/eof shift in step with vld. No shift when gp_ce=0; converter registers hold.
- m_valid = vld[1]. m_sof/m_eol = stage-1 sideband & vld[1]. Latency is 2 enabled cycles from input handshake to m_valid.
- Bubbles (gp_ce=1, no accept) insert vld=0. Output order always equals input order.
- FSM WAIT_SOF: s_ready follows gp_ce. Pixels without sof are consumed and dropped (vld bit 0). A handshake with s_sof → accept, x=1, y=0, go ACTIVE.
- FSM ACTIVE, each accepted pixel:
  - Normal pixel: x increments.
  - s_eol with x==IMG_W-1: x=0, y++.
  - s_eol with x≠IMG_W-1: err_line pulse, x=0, y++ (resync at eol).
  - x reaches IMG_W-1 without eol: err_line pulse, x=0, y++. Later stray eol bits are ignored until the count matches.
  - eol on line y==IMG_H-1: tag eof=1, return to WAIT_SOF.
  - s_sof in ACTIVE: err_frame pulse, pixel accepted as the new frame's first pixel, x=1, y=0.
- frame_done = m_valid & m_ready & eof at stage 1. Only one frame_done per frame.
- Simultaneous sof+eol on the same pixel is treated as sof, then the eol rule is applied with x=0 (IMG_W≥2 ⇒ err_line).
- Reset mid-frame flushes in-flight pixels; no frame_done is issued for that frame.

Test Plan:
- IMG_W=4, IMG_H=2, m_ready=1, continuous 8-pixel frame with R=G=B=255 → m_valid rises 2 cycles after the first handshake; m_data=255 for each pixel; m_sof on pixel 0; m_eol on pixels 3 and 7; frame_done on the pixel-7 handshake.
- Same frame, m_ready toggled 1,0,0,1,… → gp_ce=0 and s_ready=0 whenever m_valid&~m_ready; no pixel lost or duplicated; 8 outputs in order; data stable while stalled.
- Three pixels without sof, then a valid frame → first 3 dropped (no m_valid), 8 outputs follow.
- Line 0 with eol on pixel 2 (short line) → err_line pulse, y=1, no err_frame; frame completes after line 1 with frame_done.
- sof injected at pixel 5 of the frame → err_frame pulse, counters restart, next frame_done 8 pixels after the new sof.
- rst=0 for one cycle with 2 pixels in flight → m_valid=0 next cycle, state WAIT_SOF, no frame_done.
